// File: rtl/multi_ch_addr_calc.sv
// Multi-channel address sequence generator. Each channel walks base, base+stride, ...
// for length beats (optionally repeating forever); channels share one registered
// valid/ready output slot through a round-robin arbiter.
module multi_ch_addr_calc #(
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 32,
  parameter int STRIDE_W = 16,
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          start,
  input  logic [NUM_CH-1:0]          abort,
  input  logic [NUM_CH*ADDR_W-1:0]   base,
  input  logic [NUM_CH*CNT_W-1:0]    length,
  input  logic [NUM_CH*STRIDE_W-1:0] stride,
  input  logic [NUM_CH-1:0]          wrap_en,
  output logic [ADDR_W-1:0]          addr,
  output logic [CH_W-1:0]            ch_id,
  output logic                       last,
  output logic                       addr_valid,
  input  logic                       addr_ready,
  output logic [NUM_CH-1:0]          busy,
  output logic [NUM_CH-1:0]          done
);

  // LOAD is a one-cycle settling state between accepting a start and competing
  // for the output slot, so the first beat appears two edges after start.
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} ch_state_t;

  ch_state_t            state     [NUM_CH];
  logic [ADDR_W-1:0]    cur_addr  [NUM_CH];
  logic [ADDR_W-1:0]    base_l    [NUM_CH];
  logic [CNT_W-1:0]     remaining [NUM_CH];
  logic [CNT_W-1:0]     len_l     [NUM_CH];
  logic [STRIDE_W-1:0]  stride_l  [NUM_CH];
  logic [NUM_CH-1:0]    wrap_l;

  logic [CH_W-1:0]      rr;
  logic                 kill_q;
  logic [NUM_CH-1:0]    req;
  logic [NUM_CH-1:0]    accept;
  logic [NUM_CH-1:0]    zero_start;
  logic [CH_W-1:0]      cand;
  logic [CH_W-1:0]      grant_ch;
  logic                 grant_valid;
  logic                 grant_last;
  logic                 slot_free;
  logic                 do_grant;
  logic                 handshake;

  assign slot_free  = !addr_valid || addr_ready;
  assign handshake  = addr_valid && addr_ready;
  assign do_grant   = slot_free && grant_valid;
  assign grant_last = (remaining[grant_ch] == CNT_W'(1)) && !wrap_l[grant_ch];

  // Per-channel status: who may be granted, who is busy, and which starts are taken.
  // A channel counts as busy while any of its beats still sits in the output slot,
  // which also blocks a restart until that beat has been handed off.
  always_comb begin
    req        = '0;
    busy       = '0;
    accept     = '0;
    zero_start = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req[i]  = (state[i] == ACTIVE) && !abort[i];
      busy[i] = (state[i] != IDLE) || (addr_valid && (ch_id == CH_W'(i)));
      if (start[i] && !busy[i] && !abort[i]) begin
        if (length[i*CNT_W +: CNT_W] == '0)
          zero_start[i] = 1'b1;
        else
          accept[i] = 1'b1;
      end
    end
  end

  // Round-robin search starting just after the most recently granted channel.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(rr) + k) % NUM_CH);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_ch    = cand;
      end
    end
  end

  // Channel state machines: latch config on start, advance the address on each grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_l <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state[i]     <= IDLE;
        cur_addr[i]  <= '0;
        base_l[i]    <= '0;
        remaining[i] <= '0;
        len_l[i]     <= '0;
        stride_l[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (abort[i]) begin
          state[i] <= IDLE;
        end else begin
          case (state[i])
            IDLE: begin
              if (accept[i]) begin
                base_l[i]    <= base[i*ADDR_W +: ADDR_W];
                cur_addr[i]  <= base[i*ADDR_W +: ADDR_W];
                len_l[i]     <= length[i*CNT_W +: CNT_W];
                remaining[i] <= length[i*CNT_W +: CNT_W];
                stride_l[i]  <= stride[i*STRIDE_W +: STRIDE_W];
                wrap_l[i]    <= wrap_en[i];
                state[i]     <= LOAD;
              end
            end
            LOAD: state[i] <= ACTIVE;
            ACTIVE: begin
              if (do_grant && (grant_ch == CH_W'(i))) begin
                if (remaining[i] == CNT_W'(1)) begin
                  if (wrap_l[i]) begin
                    cur_addr[i]  <= base_l[i];
                    remaining[i] <= len_l[i];
                  end else begin
                    state[i] <= IDLE;
                  end
                end else begin
                  cur_addr[i]  <= cur_addr[i] + ADDR_W'(stride_l[i]);
                  remaining[i] <= remaining[i] - CNT_W'(1);
                end
              end
            end
            default: state[i] <= IDLE;
          endcase
        end
      end
    end
  end

  // Output slot: load on grant, hold under backpressure, empty when nothing to send.
  // kill_q remembers that the slotted beat's channel was aborted so it raises no done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      ch_id      <= '0;
      last       <= 1'b0;
      addr_valid <= 1'b0;
      rr         <= CH_W'(NUM_CH - 1);
      kill_q     <= 1'b0;
    end else if (do_grant) begin
      addr       <= cur_addr[grant_ch];
      ch_id      <= grant_ch;
      last       <= grant_last;
      addr_valid <= 1'b1;
      rr         <= grant_ch;
      kill_q     <= 1'b0;
    end else begin
      if (slot_free)
        addr_valid <= 1'b0;
      if (addr_valid && abort[ch_id])
        kill_q <= 1'b1;
    end
  end

  // Completion pulses: zero-length starts, or handoff of an un-aborted final beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        done[i] <= zero_start[i] ||
                   (handshake && last && !kill_q && !abort[i] && (ch_id == CH_W'(i)));
    end
  end

endmodule

// File: tb/tb_multi_ch_addr_calc.sv
// Directed bench for multi_ch_addr_calc: expected beat tables per scenario plus
// hand-written sequences for backpressure, abort, zero length and async reset.
module tb_multi_ch_addr_calc;

  localparam int ADDR_W   = 32;
  localparam int CNT_W    = 32;
  localparam int STRIDE_W = 16;
  localparam int NUM_CH   = 4;
  localparam int CH_W     = 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_CH-1:0]          start;
  logic [NUM_CH-1:0]          abort;
  logic [NUM_CH*ADDR_W-1:0]   base;
  logic [NUM_CH*CNT_W-1:0]    length;
  logic [NUM_CH*STRIDE_W-1:0] stride;
  logic [NUM_CH-1:0]          wrap_en;
  logic [ADDR_W-1:0]          addr;
  logic [CH_W-1:0]            ch_id;
  logic                       last;
  logic                       addr_valid;
  logic                       addr_ready;
  logic [NUM_CH-1:0]          busy;
  logic [NUM_CH-1:0]          done;

  multi_ch_addr_calc #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .STRIDE_W(STRIDE_W), .NUM_CH(NUM_CH), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base(base), .length(length),
    .stride(stride), .wrap_en(wrap_en), .addr(addr), .ch_id(ch_id), .last(last),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              scen;
    logic [CH_W-1:0] ch;
    logic [31:0]     addr;
    logic            last;
  } vec_t;

  typedef struct {
    logic [CH_W-1:0] ch;
    logic [31:0]     addr;
    logic            last;
    int              cyc;
  } obs_t;

  vec_t vecs[$];
  obs_t got[$];
  int   doneCnt [NUM_CH];
  int   cyc = 0;
  int   checkCount = 0;
  int   passCount = 0;

  // Cycle counter used to time-stamp observed beats.
  always @(posedge clk) cyc++;

  // Monitor: records every handshaken beat and counts done pulses per channel.
  always @(negedge clk) begin
    if (!rst) begin
      if (addr_valid && addr_ready)
        got.push_back('{ch: ch_id, addr: addr, last: last, cyc: cyc});
      for (int i = 0; i < NUM_CH; i++)
        if (done[i]) doneCnt[i]++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic failTimeout(input string name, input int cycles);
    checkCount++;
    $display("[TB] FAIL %s: no event after %0d cycles, expected event", name, cycles);
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearMon();
    got.delete();
    for (int i = 0; i < NUM_CH; i++) doneCnt[i] = 0;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    start = '0;
    abort = '0;
    addr_ready = 1'b1;
    repeat (2) waitCycle();
    rst = 1'b0;
    waitCycle();
    clearMon();
  endtask

  task automatic setChannel(input int ch, input logic [31:0] b, input logic [31:0] l,
                            input logic [15:0] s, input logic w);
    base[ch*ADDR_W +: ADDR_W]       = b;
    length[ch*CNT_W +: CNT_W]       = l;
    stride[ch*STRIDE_W +: STRIDE_W] = s;
    wrap_en[ch]                     = w;
  endtask

  task automatic applyStimulus(input logic [NUM_CH-1:0] mask, output int startCyc);
    start = mask;
    startCyc = cyc;
    waitCycle();
    start = '0;
  endtask

  task automatic waitDone(input int ch, input int maxCyc, input string name);
    int n = 0;
    while (!(doneCnt[ch] >= 1 && busy[ch] == 1'b0) && n < maxCyc) begin
      waitCycle();
      n++;
    end
    if (!(doneCnt[ch] >= 1 && busy[ch] == 1'b0)) failTimeout({name, " done"}, maxCyc);
  endtask

  task automatic addVec(input int scen, input int ch, input logic [31:0] a, input logic l);
    vecs.push_back('{scen: scen, ch: CH_W'(ch), addr: a, last: l});
  endtask

  task automatic compareScenario(input int scen, input bit exact, input string name);
    int n = 0;
    int k = 0;
    foreach (vecs[j]) if (vecs[j].scen == scen) n++;
    if (exact) checkOutput({name, " beat count"}, 32'(got.size()), 32'(n));
    else       checkOutput({name, " enough beats"}, 32'(got.size() >= n), 32'd1);
    for (int j = 0; j < vecs.size(); j++) begin
      if (vecs[j].scen == scen) begin
        if (k < got.size()) begin
          checkOutput($sformatf("%s beat%0d addr", name, k), got[k].addr, vecs[j].addr);
          checkOutput($sformatf("%s beat%0d ch_id", name, k), 32'(got[k].ch), 32'(vecs[j].ch));
          checkOutput($sformatf("%s beat%0d last", name, k), 32'(got[k].last), 32'(vecs[j].last));
        end
        k++;
      end
    end
  endtask

  task automatic runSingle(input string name);
    int sc;
    setChannel(0, 1000, 4, 1, 1'b0);
    applyStimulus(4'b0001, sc);
    waitDone(0, 30, name);
    repeat (2) waitCycle();
    compareScenario(1, 1'b1, name);
    if (got.size() >= 4) begin
      checkOutput({name, " first beat latency"}, 32'(got[0].cyc - sc), 32'd3);
      for (int k = 1; k < 4; k++)
        checkOutput($sformatf("%s beat%0d spacing", name, k), 32'(got[k].cyc - got[k-1].cyc), 32'd1);
    end
    checkOutput({name, " done count"}, 32'(doneCnt[0]), 32'd1);
    checkOutput({name, " busy after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int sc;
    int n;
    int nAtAbort;

    // Expected beat tables, one scenario id per sequence.
    addVec(1, 0, 1000, 0); addVec(1, 0, 1001, 0); addVec(1, 0, 1002, 0); addVec(1, 0, 1003, 1);
    addVec(2, 0, 1000, 0); addVec(2, 0, 1001, 0); addVec(2, 0, 1002, 0); addVec(2, 0, 1003, 1);
    addVec(3, 0, 0, 0);    addVec(3, 1, 100524, 0); addVec(3, 0, 4, 0);
    addVec(3, 1, 100532, 0); addVec(3, 0, 8, 1);  addVec(3, 1, 100540, 1);
    addVec(4, 2, 200, 0);  addVec(4, 2, 202, 0);  addVec(4, 2, 204, 0);
    addVec(4, 2, 200, 0);  addVec(4, 2, 202, 0);
    addVec(6, 0, 32'hFFFF_FFFE, 0); addVec(6, 0, 32'h0000_0002, 1);

    rst = 1'b1; start = '0; abort = '0; addr_ready = 1'b1;
    base = '0; length = '0; stride = '0; wrap_en = '0;
    @(negedge clk);
    checkOutput("reset addr", addr, 32'd0);
    checkOutput("reset ch_id", 32'(ch_id), 32'd0);
    checkOutput("reset last", 32'(last), 32'd0);
    checkOutput("reset addr_valid", 32'(addr_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);

    $display("[TB] single channel sequence");
    resetDut();
    runSingle("s1");

    $display("[TB] backpressure on second beat");
    resetDut();
    setChannel(0, 1000, 4, 1, 1'b0);
    applyStimulus(4'b0001, sc);
    n = 0;
    while (got.size() < 1 && n < 20) begin waitCycle(); n++; end
    if (got.size() < 1) failTimeout("s2 first beat", 20);
    addr_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      checkOutput($sformatf("s2 hold%0d valid", r), 32'(addr_valid), 32'd1);
      checkOutput($sformatf("s2 hold%0d addr", r), addr, 32'd1001);
      checkOutput($sformatf("s2 hold%0d last", r), 32'(last), 32'd0);
      waitCycle();
    end
    addr_ready = 1'b1;
    waitDone(0, 30, "s2");
    repeat (2) waitCycle();
    compareScenario(2, 1'b1, "s2");
    checkOutput("s2 done count", 32'(doneCnt[0]), 32'd1);

    $display("[TB] two channels together");
    resetDut();
    setChannel(0, 0, 3, 4, 1'b0);
    setChannel(1, 100524, 3, 8, 1'b0);
    applyStimulus(4'b0011, sc);
    waitDone(0, 30, "s3 ch0");
    waitDone(1, 30, "s3 ch1");
    repeat (2) waitCycle();
    compareScenario(3, 1'b1, "s3");
    checkOutput("s3 done0 count", 32'(doneCnt[0]), 32'd1);
    checkOutput("s3 done1 count", 32'(doneCnt[1]), 32'd1);

    $display("[TB] wrap mode then abort");
    resetDut();
    setChannel(2, 200, 3, 2, 1'b1);
    applyStimulus(4'b0100, sc);
    n = 0;
    while (got.size() < 5 && n < 30) begin waitCycle(); n++; end
    if (got.size() < 5) failTimeout("s4 wrap beats", 30);
    abort = 4'b0100;
    nAtAbort = got.size();
    waitCycle();
    abort = '0;
    repeat (5) waitCycle();
    checkOutput("s4 beats after abort", 32'(got.size() <= nAtAbort + 1), 32'd1);
    compareScenario(4, 1'b0, "s4");
    checkOutput("s4 done count", 32'(doneCnt[2]), 32'd0);
    checkOutput("s4 busy after abort", 32'(busy), 32'd0);
    checkOutput("s4 valid after abort", 32'(addr_valid), 32'd0);

    $display("[TB] zero length start");
    resetDut();
    setChannel(1, 500, 0, 1, 1'b0);
    start = 4'b0010;
    waitCycle();
    start = '0;
    @(negedge clk);
    checkOutput("s5 done pulse", 32'(done), 32'b0010);
    waitCycle();
    @(negedge clk);
    checkOutput("s5 done cleared", 32'(done), 32'd0);
    repeat (3) waitCycle();
    checkOutput("s5 no beats", 32'(got.size()), 32'd0);
    checkOutput("s5 busy", 32'(busy), 32'd0);
    checkOutput("s5 done count", 32'(doneCnt[1]), 32'd1);

    $display("[TB] address overflow");
    resetDut();
    setChannel(0, 32'hFFFF_FFFE, 2, 4, 1'b0);
    applyStimulus(4'b0001, sc);
    waitDone(0, 30, "s6");
    repeat (2) waitCycle();
    compareScenario(6, 1'b1, "s6");

    $display("[TB] async reset mid-sequence");
    resetDut();
    setChannel(0, 1000, 4, 1, 1'b0);
    applyStimulus(4'b0001, sc);
    n = 0;
    while (!addr_valid && n < 20) begin @(negedge clk); n++; end
    if (!addr_valid) failTimeout("s7 first valid", 20);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("s7 rst addr", addr, 32'd0);
    checkOutput("s7 rst ch_id", 32'(ch_id), 32'd0);
    checkOutput("s7 rst last", 32'(last), 32'd0);
    checkOutput("s7 rst addr_valid", 32'(addr_valid), 32'd0);
    checkOutput("s7 rst busy", 32'(busy), 32'd0);
    checkOutput("s7 rst done", 32'(done), 32'd0);
    resetDut();
    repeat (3) waitCycle();
    checkOutput("s7 no stray done", 32'(doneCnt[0]), 32'd0);
    clearMon();
    runSingle("s7 rerun");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
